// File: rtl/hub75_scan_sequencer.sv
// hub75_scan_sequencer: HUB-75 scan engine with BCM timing; display of one plane overlaps shifting of the next.
module hub75_scan_sequencer #(
  parameter int COLUMN_COUNT = 64,
  parameter int ROW_PAIRS = 16,
  parameter int PLANE_COUNT = 8,
  parameter int CLOCK_DIVIDE = 2,
  parameter int BASE_OE_CYCLES = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic [$clog2(COLUMN_COUNT)-1:0] read_column,
  output logic [$clog2(ROW_PAIRS)-1:0] read_row,
  output logic [$clog2(PLANE_COUNT)-1:0] read_plane,
  input  logic [5:0] rgb_in,
  output logic [5:0] hub_rgb,
  output logic hub_clk,
  output logic hub_lat,
  output logic hub_oe_n,
  output logic [$clog2(ROW_PAIRS)-1:0] hub_addr,
  output logic frame_start,
  output logic busy
);
  localparam int CW = $clog2(COLUMN_COUNT);
  localparam int RW = $clog2(ROW_PAIRS);
  localparam int PW = $clog2(PLANE_COUNT);
  localparam int TW = $clog2((BASE_OE_CYCLES << (PLANE_COUNT - 1)) + 1);
  localparam int PHN = 2 * CLOCK_DIVIDE > BLANK_CYCLES ? 2 * CLOCK_DIVIDE : BLANK_CYCLES;
  localparam int PHW = $clog2(PHN);
  localparam logic [PHW-1:0] PH_ONE = PHW'(1);
  localparam logic [PHW-1:0] PH_HALF = PHW'(CLOCK_DIVIDE - 1);
  localparam logic [PHW-1:0] PH_LAST = PHW'(2 * CLOCK_DIVIDE - 1);
  localparam logic [PHW-1:0] PH_BLANK = PHW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLUMN_COUNT - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW_PAIRS - 1);
  localparam logic [PW-1:0] PLANE_LAST = PW'(PLANE_COUNT - 1);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SHIFT = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] BLANK = 3'd3;
  localparam logic [2:0] LATCH = 3'd4;
  localparam logic [2:0] DRAIN = 3'd5;
  logic [2:0] state, state_next;
  logic [PHW-1:0] phase, phase_next;
  logic [TW-1:0] timer, timer_next;
  logic [CW-1:0] col_next;
  logic [RW-1:0] row_next;
  logic [PW-1:0] plane_next;
  logic start_next;
  logic frame_end;
  assign frame_end = read_row == ROW_LAST && read_plane == PLANE_LAST;
  // Timer decision uses the post-decrement value so expiry coinciding with the last shift skips WAIT.
  always_comb begin
    state_next = state;
    phase_next = phase;
    col_next = read_column;
    row_next = read_row;
    plane_next = read_plane;
    start_next = 1'b0;
    timer_next = timer == '0 ? timer : timer - 1'b1;
    case (state)
      IDLE: if (enable) begin
        state_next = SHIFT;
        phase_next = '0;
        col_next = '0;
        row_next = '0;
        plane_next = '0;
        start_next = 1'b1;
      end
      SHIFT: begin
        phase_next = phase == PH_LAST ? '0 : phase + PH_ONE;
        if (phase == PH_LAST) begin
          col_next = read_column == COL_LAST ? '0 : read_column + 1'b1;
          if (read_column == COL_LAST) state_next = timer_next != '0 ? WAIT : BLANK;
        end
      end
      WAIT: state_next = timer_next == '0 ? BLANK : WAIT;
      BLANK: begin
        phase_next = phase == PH_BLANK ? '0 : phase + PH_ONE;
        state_next = phase == PH_BLANK ? LATCH : BLANK;
      end
      LATCH: begin
        phase_next = phase == PH_LAST ? '0 : phase + PH_ONE;
        if (phase == PH_LAST) begin
          timer_next = TW'(BASE_OE_CYCLES) << read_plane;
          plane_next = read_plane == PLANE_LAST ? '0 : read_plane + 1'b1;
          if (read_plane == PLANE_LAST) row_next = read_row == ROW_LAST ? '0 : read_row + 1'b1;
          state_next = frame_end && !enable ? DRAIN : SHIFT;
          start_next = frame_end && enable;
        end
      end
      DRAIN: state_next = timer_next == '0 ? IDLE : DRAIN;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      phase <= '0;
      timer <= '0;
      read_column <= '0;
      read_row <= '0;
      read_plane <= '0;
      hub_rgb <= '0;
      hub_clk <= 1'b0;
      hub_lat <= 1'b0;
      hub_oe_n <= 1'b1;
      hub_addr <= '0;
      frame_start <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_next;
      phase <= phase_next;
      timer <= timer_next;
      read_column <= col_next;
      read_row <= row_next;
      read_plane <= plane_next;
      frame_start <= start_next;
      busy <= state_next != IDLE;
      hub_clk <= state_next == SHIFT && phase_next > PH_HALF;
      hub_lat <= state_next == LATCH;
      hub_oe_n <= !(timer_next != '0 && state_next != BLANK && state_next != LATCH);
      if (state == SHIFT && phase == PH_ONE) hub_rgb <= rgb_in;
      if (state_next == BLANK && state != BLANK) hub_addr <= read_row;
    end
  end
endmodule

// File: tb/tb_hub75_scan_sequencer.sv
// tb_hub75_scan_sequencer: randomized scoreboard bench; expected pin events come from a frame-level model.
module tb_hub75_scan_sequencer;
  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int PLANES = 2;
  localparam int CD = 2;
  localparam int BASE = 8;
  localparam int BLANKC = 2;
  localparam int SHIFT_CYC = COLS * 2 * CD;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic [1:0] read_column;
  logic [0:0] read_row, read_plane, hub_addr;
  logic [5:0] rgb_in = '0;
  logic [5:0] hub_rgb;
  logic hub_clk, hub_lat, hub_oe_n, frame_start, busy;
  int total = 0, bad = 0, fs_count = 0;
  logic [5:0] fb [ROWS][PLANES][COLS];
  typedef struct {int rgb; bit first;} col_t;
  col_t q_rgb[$];
  int q_gap[$], q_addr[$], q_oe[$];
  col_t e;
  bit p_clk, p_lat, p_oe, p_fs;
  int p_addr, gap, lat_w, oe_w, rise_gap, rises, held;

  hub75_scan_sequencer #(
    .COLUMN_COUNT(COLS), .ROW_PAIRS(ROWS), .PLANE_COUNT(PLANES),
    .CLOCK_DIVIDE(CD), .BASE_OE_CYCLES(BASE), .BLANK_CYCLES(BLANKC)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .read_column(read_column), .read_row(read_row), .read_plane(read_plane),
    .rgb_in(rgb_in), .hub_rgb(hub_rgb), .hub_clk(hub_clk), .hub_lat(hub_lat),
    .hub_oe_n(hub_oe_n), .hub_addr(hub_addr), .frame_start(frame_start), .busy(busy)
  );

  always #5 clock = ~clock;
  // Synchronous framebuffer: data appears one cycle after the address.
  always @(posedge clock) rgb_in <= fb[read_row][read_plane][read_column];

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(string name);
    total++;
    bad++;
    $display("FAIL %s: no expected event or bound expired at %0t", name, $time);
  endtask

  task automatic fill_fb(bit pattern);
    for (int r = 0; r < ROWS; r++)
      for (int p = 0; p < PLANES; p++)
        for (int c = 0; c < COLS; c++)
          fb[r][p][c] = pattern ? 6'(c) : 6'($urandom);
  endtask

  // Frame-level model: per row/plane, one hub_clk rise per column, then a latch of that row,
  // then a display of BASE<<plane; WAIT only appears when the previous display outlasts the shift.
  task automatic start_run(int n);
    int prev;
    prev = 0;
    for (int f = 0; f < n; f++)
      for (int r = 0; r < ROWS; r++)
        for (int p = 0; p < PLANES; p++) begin
          for (int c = 0; c < COLS; c++) q_rgb.push_back('{int'(fb[r][p][c]), c == 0});
          q_gap.push_back((prev > SHIFT_CYC ? prev - SHIFT_CYC : 0) + BLANKC);
          q_addr.push_back(r);
          q_oe.push_back(BASE << p);
          prev = BASE << p;
        end
  endtask

  task automatic clear_q();
    q_rgb.delete();
    q_gap.delete();
    q_addr.delete();
    q_oe.delete();
  endtask

  task automatic check_idle(string tag);
    chk({tag, "_clk"}, int'(hub_clk), 0);
    chk({tag, "_lat"}, int'(hub_lat), 0);
    chk({tag, "_oe_n"}, int'(hub_oe_n), 1);
    chk({tag, "_addr"}, int'(hub_addr), 0);
    chk({tag, "_rgb"}, int'(hub_rgb), 0);
    chk({tag, "_rd_col"}, int'(read_column), 0);
    chk({tag, "_rd_row"}, int'(read_row), 0);
    chk({tag, "_rd_plane"}, int'(read_plane), 0);
    chk({tag, "_fs"}, int'(frame_start), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic check_first(string tag);
    chk({tag, "_fs"}, int'(frame_start), 1);
    chk({tag, "_col"}, int'(read_column), 0);
    chk({tag, "_row"}, int'(read_row), 0);
    chk({tag, "_plane"}, int'(read_plane), 0);
    chk({tag, "_busy"}, int'(busy), 1);
  endtask

  task automatic finish_run(int n, int fsb);
    int k;
    k = 0;
    while (fs_count < fsb + n && k < 1000) begin @(negedge clock); k++; end
    if (k >= 1000) fail("frame_start_wait");
    repeat ($urandom_range(1, 60)) @(negedge clock);
    enable = 1'b0;
    k = 0;
    while (busy && k < 1000) begin @(negedge clock); k++; end
    if (k >= 1000) fail("drain_wait");
    @(negedge clock);
    chk("frames_run", fs_count - fsb, n);
    chk("rgb_events_left", q_rgb.size(), 0);
    chk("latch_events_left", q_addr.size(), 0);
    chk("display_events_left", q_oe.size(), 0);
    chk("idle_oe_n", int'(hub_oe_n), 1);
    chk("idle_busy", int'(busy), 0);
  endtask

  task automatic reset_during(bit in_latch);
    int k, fsb;
    fill_fb(0);
    start_run(2);
    enable = 1'b1;
    k = 0;
    while ((in_latch ? !hub_lat : hub_oe_n) && k < 1000) begin @(negedge clock); k++; end
    if (k >= 1000) fail("reset_point_wait");
    #2 reset = 1'b0;
    #1;
    chk("arst_lat", int'(hub_lat), 0);
    chk("arst_oe_n", int'(hub_oe_n), 1);
    chk("arst_clk", int'(hub_clk), 0);
    chk("arst_busy", int'(busy), 0);
    clear_q();
    repeat (3) @(negedge clock);
    fill_fb(0);
    start_run(1);
    fsb = fs_count;
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    check_first("restart");
    finish_run(1, fsb);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      p_clk = 0; p_lat = 0; p_oe = 1; p_fs = 0; p_addr = 0;
      gap = 0; lat_w = 0; oe_w = 0; rise_gap = 0; rises = 0; held = 0;
    end else begin
      rise_gap++;
      if (hub_clk && !p_clk) begin
        if (q_rgb.size() == 0) fail("unexpected_hub_clk");
        else begin
          e = q_rgb.pop_front();
          chk("hub_rgb_at_rise", int'(hub_rgb), e.rgb);
          if (!e.first) chk("hub_clk_spacing", rise_gap, 2 * CD);
        end
        rise_gap = 0;
        held = int'(hub_rgb);
        rises++;
      end else if (hub_clk) chk("hub_rgb_stable", int'(hub_rgb), held);
      if (hub_lat && !p_lat) begin
        if (q_addr.size() == 0 || q_gap.size() == 0) fail("unexpected_latch");
        else begin
          chk("blank_before_latch", gap, q_gap.pop_front());
          chk("latched_row", int'(hub_addr), q_addr.pop_front());
        end
        chk("clks_per_row", rises, COLS);
        rises = 0;
        lat_w = 0;
      end
      if (hub_lat) begin
        lat_w++;
        chk("oe_n_during_latch", int'(hub_oe_n), 1);
      end
      if (!hub_lat && p_lat) chk("latch_width", lat_w, 2 * CD);
      if (!hub_oe_n) oe_w++;
      if (hub_oe_n && !p_oe) begin
        if (q_oe.size() == 0) fail("unexpected_display");
        else chk("display_width", oe_w, q_oe.pop_front());
        oe_w = 0;
      end
      if (int'(hub_addr) != p_addr) begin
        chk("addr_change_oe_n", int'(hub_oe_n), 1);
        chk("addr_change_lat", int'(hub_lat), 0);
      end
      if (frame_start) begin
        chk("frame_start_single", int'(p_fs), 0);
        chk("frame_start_col", int'(read_column), 0);
        chk("frame_start_row", int'(read_row), 0);
        chk("frame_start_plane", int'(read_plane), 0);
        fs_count++;
      end
      gap = hub_clk ? 0 : gap + 1;
      p_clk = hub_clk; p_lat = hub_lat; p_oe = hub_oe_n; p_fs = frame_start; p_addr = int'(hub_addr);
    end
  end

  initial begin
    int fsb, n;
    fill_fb(1);
    enable = 1'b1;
    repeat (4) @(negedge clock);
    check_idle("in_reset");
    start_run(2);
    fsb = fs_count;
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    check_first("first_read");
    finish_run(2, fsb);
    fill_fb(0);
    start_run(3);
    fsb = fs_count;
    enable = 1'b1;
    finish_run(3, fsb);
    reset_during(1);
    reset_during(0);
    repeat (3) begin
      n = $urandom_range(1, 2);
      fill_fb(0);
      start_run(n);
      fsb = fs_count;
      enable = 1'b1;
      finish_run(n, fsb);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hub75_scan_sequencer.md
Name: hub75_scan_sequencer

Overview:
- Top-level HUB-75 panel scan engine. Walks column, row and bit-plane in a nested cascade: column is the fastest index, then plane, then row.
- Issues framebuffer read addresses and shifts the returned RGB bits out on the panel's serial clock. Drives latch, output-enable and the row address.
- Uses binary-coded-modulation (BCM) display timing: display of the latched row/plane overlaps shifting of the next one.
- Sits between the framebuffer read port and the panel pins.

Parameters:
- COLUMN_COUNT, 64, panel columns shifted per row.
- ROW_PAIRS, 16, scan rows (addressed rows); address width is clog2(ROW_PAIRS).
- PLANE_COUNT, 8, BCM bit planes per colour.
- CLOCK_DIVIDE, 2, system clocks per hub_clk half-period. Must be >= 2.
- BASE_OE_CYCLES, 8, display (OE on) time of plane 0 in system clocks; plane p displays BASE_OE_CYCLES << p.
- BLANK_CYCLES, 2, OE-off guard cycles before and around latch/address change.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- enable  in  1  run request.
- read_column  out  clog2(COLUMN_COUNT)  framebuffer column address.
- read_row  out  clog2(ROW_PAIRS)  framebuffer row address.
- read_plane  out  clog2(PLANE_COUNT)  framebuffer bit-plane index.
- rgb_in  in  6  {r0,g0,b0,r1,g1,b1} bits; valid exactly 1 cycle after the address.
- hub_rgb  out  6  panel data pins.
- hub_clk  out  1  panel shift clock.
- hub_lat  out  1  panel latch.
- hub_oe_n  out  1  panel output enable, active low.
- hub_addr  out  clog2(ROW_PAIRS)  panel row address.
- frame_start  out  1  one-cycle pulse at the first read of row 0, plane 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any time, including mid-shift or mid-display): all state returns to IDLE and the display timer is cleared. Outputs take these values: hub_clk=0, hub_lat=0, hub_oe_n=1, hub_addr=0, hub_rgb=0, read_*=0, frame_start=0, busy=0. Outputs are registered and change only on clock edges after reset release.
- States: IDLE, SHIFT, WAIT, BLANK, LATCH.
- IDLE -> SHIFT when enable=1. Indices are zeroed and frame_start pulses in the first SHIFT cycle.
- SHIFT: each column takes 2*CLOCK_DIVIDE cycles.
  - Cycle 0 of a column: the read address is presented.
  - Cycle 1: hub_rgb <= rgb_in. It is held for the rest of the column.
  - hub_clk is 0 for the first CLOCK_DIVIDE cycles and 1 for the last CLOCK_DIVIDE cycles.
  - After column COLUMN_COUNT-1 the FSM goes to WAIT, with hub_clk returning to 0.
- WAIT: holds while the display timer is nonzero, then goes to BLANK. It takes zero cycles (passes straight through) if the timer is already 0.
- BLANK: hub_oe_n=1 for BLANK_CYCLES, then LATCH. hub_addr updates to the shifted row in the first BLANK cycle.
- LATCH: hub_lat=1 for 2*CLOCK_DIVIDE cycles, with hub_oe_n=1. On exit:
  - the display timer loads BASE_OE_CYCLES << plane;
  - the indices advance: plane wraps to 0 and increments row; row wraps to 0 at frame end;
  - the FSM goes back to SHIFT.
- Display timer:
  - Decrements every cycle while nonzero.
  - hub_oe_n = 0 exactly when the timer is nonzero and the state is not BLANK or LATCH.
  - Its width holds BASE_OE_CYCLES << (PLANE_COUNT-1) without overflow.
- enable is sampled only in IDLE and at the LATCH exit that ends a frame (row ROW_PAIRS-1, plane PLANE_COUNT-1).
  - If enable=0 at that exit, the FSM goes to WAIT-like draining: it waits for the timer to expire, then goes to IDLE with hub_oe_n=1.
  - Deassertion mid-frame has no effect until the frame boundary.
- frame_start re-pulses at the start of every frame.
- Simultaneous timer expiry and SHIFT completion: WAIT is skipped (0 cycles), never a 1-cycle stall.

Test Plan:
All scenarios use COLUMN_COUNT=4, ROW_PAIRS=2, PLANE_COUNT=2, CLOCK_DIVIDE=2, BASE_OE_CYCLES=8, BLANK_CYCLES=2.
1. Reset held with enable=1 -> outputs stay at reset values and busy=0. Release reset -> frame_start pulses once in the cycle after IDLE exit; the first read address is (col 0, row 0, plane 0).
2. Model framebuffer returning rgb_in = column index pattern -> 4 hub_clk rising edges per row/plane, each 4 cycles apart. hub_rgb is stable on every rising edge and equals the data for that column.
3. First latch -> BLANK 2 cycles, then hub_lat high 4 cycles, hub_oe_n=1 throughout. Then hub_oe_n is low for exactly 8 cycles (plane 0), and exactly 16 cycles after the plane-1 latch.
4. hub_addr changes only while hub_oe_n=1 and never during hub_lat=1 -> assertion over 3 full frames; the row sequence is 0,0,1,1,0,... (one entry per plane).
5. Deassert enable mid-frame -> the frame completes, the last display runs its full 16 cycles, then busy=0 and hub_oe_n=1. Reassert -> a new frame_start pulse.
6. Assert reset during LATCH and during display -> same cycle async: hub_lat=0, hub_oe_n=1. After release the sequence restarts at row 0, plane 0.
